// File: rtl/csi_capture_ctrl.sv
// ---------------------------------------------------------------------------
// csi_capture_ctrl
//
// Capture controller for a channel-state-information front end. It waits to
// be armed, then looks for a short preamble followed by a long preamble. Once
// the long preamble is found, it writes a fixed-length run of I/Q samples into
// an external capture buffer. After that it signals completion, sits in a
// hold-off window, and either re-arms itself or returns to idle.
//
// Ports
//   clk_in                  single clock, all logic on the rising edge
//   rst_in                  synchronous active-high reset
//   sample_in[31:0]         I[31:16] / Q[15:0] sample, aligned with detectors
//   sample_in_valid         sample qualifier
//   short_preamble_detected one-cycle pulse from the short-preamble detector
//   long_preamble_detected  one-cycle pulse from the long-preamble detector
//   arm_in                  pulse, starts a search from IDLE
//   auto_rearm_in           level, HOLDOFF exits to SEARCH_SHORT when high
//   abort_in                pulse, forces IDLE on the next cycle
//   long_search_en          high in SEARCH_LONG only (long detector enable)
//   wr_en                   capture buffer write strobe
//   wr_addr[ADDR_WIDTH-1:0] capture buffer write address
//   wr_data[31:0]           capture buffer write data
//   capture_done            one-cycle pulse (the DONE state)
//   busy                    high in every state except IDLE
//   state_out[2:0]          IDLE=0 SEARCH_SHORT=1 SEARCH_LONG=2 CAPTURE=3
//                           DONE=4 HOLDOFF=5
//   timeout_count[15:0]     saturating count of long-preamble timeouts
// ---------------------------------------------------------------------------
module csi_capture_ctrl #(
    parameter int LONG_TIMEOUT = 320,
    parameter int CAPTURE_LEN  = 64,
    parameter int ADDR_WIDTH   = 6,
    parameter int HOLDOFF      = 16
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic [31:0]           sample_in,
    input  logic                  sample_in_valid,
    input  logic                  short_preamble_detected,
    input  logic                  long_preamble_detected,
    input  logic                  arm_in,
    input  logic                  auto_rearm_in,
    input  logic                  abort_in,
    output logic                  long_search_en,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [31:0]           wr_data,
    output logic                  capture_done,
    output logic                  busy,
    output logic [2:0]            state_out,
    output logic [15:0]           timeout_count
);

    // The long-search timer only needs to hold 0..LONG_TIMEOUT-1.
    localparam int TIMER_W = (LONG_TIMEOUT > 1) ? $clog2(LONG_TIMEOUT) : 1;

    // A zero hold-off still spends one cycle in HOLDOFF.
    localparam int HOLD_CYCLES = (HOLDOFF > 0) ? HOLDOFF : 1;
    localparam int HOLD_W      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [TIMER_W-1:0]    TIMER_LAST = TIMER_W'(LONG_TIMEOUT - 1);
    localparam logic [HOLD_W-1:0]     HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = ADDR_WIDTH'(CAPTURE_LEN - 1);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        SEARCH_SHORT = 3'd1,
        SEARCH_LONG  = 3'd2,
        CAPTURE      = 3'd3,
        DONE         = 3'd4,
        HOLDOFF_ST   = 3'd5
    } state_t;

    state_t                  state_q;
    state_t                  state_next;
    logic [TIMER_W-1:0]      timer_q;
    logic [HOLD_W-1:0]       hold_q;
    logic [ADDR_WIDTH-1:0]   cap_count_q;

    logic                    timer_clear;
    logic                    timer_inc;
    logic                    timeout_hit;
    logic                    capture_start;
    logic                    sample_accept;
    logic                    hold_clear;
    logic                    hold_inc;

    // State register. Reset wins over every input, abort included.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // Next-state logic plus the one-cycle strobes that steer the datapath.
    // In SEARCH_LONG a long detect beats a short restart, which beats the
    // timeout, so a long detect coinciding with the final valid sample still
    // captures. Abort is applied last so that it masks every strobe: no
    // write, no timeout increment and no timer movement on the abort cycle.
    always_comb begin
        state_next    = state_q;
        timer_clear   = 1'b0;
        timer_inc     = 1'b0;
        timeout_hit   = 1'b0;
        capture_start = 1'b0;
        sample_accept = 1'b0;
        hold_clear    = 1'b0;
        hold_inc      = 1'b0;

        case (state_q)
            IDLE: begin
                if (arm_in) begin
                    state_next = SEARCH_SHORT;
                end
            end

            SEARCH_SHORT: begin
                if (short_preamble_detected) begin
                    state_next  = SEARCH_LONG;
                    timer_clear = 1'b1;
                end
            end

            SEARCH_LONG: begin
                if (long_preamble_detected) begin
                    state_next    = CAPTURE;
                    capture_start = 1'b1;
                end else if (short_preamble_detected) begin
                    timer_clear = 1'b1;
                end else if (sample_in_valid) begin
                    if (timer_q == TIMER_LAST) begin
                        state_next  = SEARCH_SHORT;
                        timeout_hit = 1'b1;
                    end else begin
                        timer_inc = 1'b1;
                    end
                end
            end

            CAPTURE: begin
                if (sample_in_valid) begin
                    sample_accept = 1'b1;
                    if (cap_count_q == ADDR_LAST) begin
                        state_next = DONE;
                    end
                end
            end

            DONE: begin
                state_next = HOLDOFF_ST;
                hold_clear = 1'b1;
            end

            HOLDOFF_ST: begin
                if (hold_q == HOLD_LAST) begin
                    state_next = auto_rearm_in ? SEARCH_SHORT : IDLE;
                end else begin
                    hold_inc = 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        if (abort_in) begin
            state_next    = IDLE;
            timer_clear   = 1'b0;
            timer_inc     = 1'b0;
            timeout_hit   = 1'b0;
            capture_start = 1'b0;
            sample_accept = 1'b0;
            hold_clear    = 1'b0;
            hold_inc      = 1'b0;
        end
    end

    // Long-search timer and the saturating timeout counter.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            timer_q       <= '0;
            timeout_count <= '0;
        end else begin
            if (timer_clear) begin
                timer_q <= '0;
            end else if (timer_inc) begin
                timer_q <= timer_q + 1'b1;
            end
            if (timeout_hit && (timeout_count != 16'hFFFF)) begin
                timeout_count <= timeout_count + 16'd1;
            end
        end
    end

    // Hold-off cycle counter, cleared while passing through DONE.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            hold_q <= '0;
        end else if (hold_clear) begin
            hold_q <= '0;
        end else if (hold_inc) begin
            hold_q <= hold_q + 1'b1;
        end
    end

    // Write port. An accepted sample is registered so the write appears one
    // cycle later, carrying the address it was accepted for. cap_count_q is
    // the address the next accepted sample will use; it wraps after the last
    // slot so the address never leaves 0..CAPTURE_LEN-1.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            cap_count_q <= '0;
        end else begin
            wr_en <= sample_accept;
            if (capture_start) begin
                wr_addr     <= '0;
                cap_count_q <= '0;
            end else if (sample_accept) begin
                wr_addr     <= cap_count_q;
                wr_data     <= sample_in;
                cap_count_q <= (cap_count_q == ADDR_LAST) ? '0 : cap_count_q + 1'b1;
            end
        end
    end

    // Status outputs are plain decodes of the registered state.
    assign state_out      = state_q;
    assign busy           = (state_q != IDLE);
    assign long_search_en = (state_q == SEARCH_LONG);
    assign capture_done   = (state_q == DONE);

endmodule

// File: tb/tb_csi_capture_ctrl.sv
// ---------------------------------------------------------------------------
// tb_csi_capture_ctrl
//
// Self-checking bench for csi_capture_ctrl. It uses LONG_TIMEOUT=8,
// CAPTURE_LEN=4 and HOLDOFF=2. A behavioural model tracks the expected
// outputs every cycle. Directed scenarios pin the model with hand-computed
// literals, and a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_csi_capture_ctrl;

    localparam int LONG_TIMEOUT = 8;
    localparam int CAPTURE_LEN  = 4;
    localparam int ADDR_WIDTH   = 3;
    localparam int HOLDOFF      = 2;

    logic                  clk_in = 1'b0;
    logic                  rst_in = 1'b1;
    logic [31:0]           sample_in = '0;
    logic                  sample_in_valid = 1'b0;
    logic                  short_preamble_detected = 1'b0;
    logic                  long_preamble_detected = 1'b0;
    logic                  arm_in = 1'b0;
    logic                  auto_rearm_in = 1'b0;
    logic                  abort_in = 1'b0;
    logic                  long_search_en;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [31:0]           wr_data;
    logic                  capture_done;
    logic                  busy;
    logic [2:0]            state_out;
    logic [15:0]           timeout_count;

    csi_capture_ctrl #(
        .LONG_TIMEOUT(LONG_TIMEOUT),
        .CAPTURE_LEN (CAPTURE_LEN),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .HOLDOFF     (HOLDOFF)
    ) dut (
        .clk_in                 (clk_in),
        .rst_in                 (rst_in),
        .sample_in              (sample_in),
        .sample_in_valid        (sample_in_valid),
        .short_preamble_detected(short_preamble_detected),
        .long_preamble_detected (long_preamble_detected),
        .arm_in                 (arm_in),
        .auto_rearm_in          (auto_rearm_in),
        .abort_in               (abort_in),
        .long_search_en         (long_search_en),
        .wr_en                  (wr_en),
        .wr_addr                (wr_addr),
        .wr_data                (wr_data),
        .capture_done           (capture_done),
        .busy                   (busy),
        .state_out              (state_out),
        .timeout_count          (timeout_count)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    // Behavioural model state (states numbered as on state_out).
    bit          m_ready = 1'b0;
    int          m_state = 0;
    int          m_valids = 0;
    int          m_written = 0;
    int          m_hold_left = 0;
    int          m_tcount = 0;
    bit          m_wr_en = 1'b0;
    int          m_wr_addr = 0;
    logic [31:0] m_wr_data = '0;
    bit          m_after_reset = 1'b0;

    // DUT-observed write log and capture_done pulse count for literal checks.
    int log_addr[$];
    logic [31:0] log_data[$];
    int done_pulses = 0;

    task automatic checkOne(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge, from the inputs the DUT samples.
    task automatic modelStep();
        m_wr_en       = 1'b0;
        m_after_reset = 1'b0;
        if (rst_in) begin
            m_ready       = 1'b1;
            m_state       = 0;
            m_valids      = 0;
            m_written     = 0;
            m_hold_left   = 0;
            m_tcount      = 0;
            m_wr_addr     = 0;
            m_wr_data     = '0;
            m_after_reset = 1'b1;
        end else if (abort_in) begin
            m_state = 0;
        end else begin
            case (m_state)
                0: if (arm_in) m_state = 1;
                1: if (short_preamble_detected) begin
                    m_state  = 2;
                    m_valids = 0;
                end
                2: begin
                    if (long_preamble_detected) begin
                        m_state   = 3;
                        m_written = 0;
                    end else if (short_preamble_detected) begin
                        m_valids = 0;
                    end else if (sample_in_valid) begin
                        m_valids++;
                        if (m_valids >= LONG_TIMEOUT) begin
                            m_state = 1;
                            if (m_tcount < 65535) m_tcount++;
                        end
                    end
                end
                3: if (sample_in_valid) begin
                    m_wr_en   = 1'b1;
                    m_wr_data = sample_in;
                    m_wr_addr = m_written;
                    m_written++;
                    if (m_written == CAPTURE_LEN) m_state = 4;
                end
                4: begin
                    m_state     = 5;
                    m_hold_left = (HOLDOFF > 0) ? HOLDOFF : 1;
                end
                5: begin
                    m_hold_left--;
                    if (m_hold_left == 0) m_state = auto_rearm_in ? 1 : 0;
                end
                default: m_state = 0;
            endcase
        end
    endtask

    task automatic checkOutput();
        checkOne("state_out", 32'(state_out), 32'(m_state));
        checkOne("busy", 32'(busy), 32'(m_state != 0));
        checkOne("long_search_en", 32'(long_search_en), 32'(m_state == 2));
        checkOne("capture_done", 32'(capture_done), 32'(m_state == 4));
        checkOne("wr_en", 32'(wr_en), 32'(m_wr_en));
        checkOne("timeout_count", 32'(timeout_count), 32'(m_tcount));
        checkOne("wr_addr range", 32'(int'(wr_addr) <= CAPTURE_LEN - 1), 32'd1);
        if (m_wr_en || m_after_reset) begin
            checkOne("wr_addr", 32'(wr_addr), 32'(m_wr_addr));
            checkOne("wr_data", wr_data, m_wr_data);
        end
    endtask

    // Single compare process: model update on the edge, compare 1 time unit later.
    always @(posedge clk_in) begin
        modelStep();
        #1;
        if (m_ready) checkOutput();
        if (wr_en) begin
            log_addr.push_back(int'(wr_addr));
            log_data.push_back(wr_data);
        end
        if (capture_done) done_pulses++;
    end

    // Drive one cycle's worth of inputs on the falling edge.
    task automatic applyStimulus(input bit v, input logic [31:0] s, input bit sh,
                                 input bit lg, input bit ar, input bit ab, input bit rs);
        @(negedge clk_in);
        sample_in_valid         = v;
        sample_in               = s;
        short_preamble_detected = sh;
        long_preamble_detected  = lg;
        arm_in                  = ar;
        abort_in                = ab;
        rst_in                  = rs;
    endtask

    // Apply inputs and wait until the edge that samples them has settled.
    task automatic step(input bit v, input logic [31:0] s, input bit sh,
                        input bit lg, input bit ar, input bit ab, input bit rs);
        applyStimulus(v, s, sh, lg, ar, ab, rs);
        @(posedge clk_in);
        #2;
    endtask

    task automatic clearLog();
        log_addr.delete();
        log_data.delete();
        done_pulses = 0;
    endtask

    // Run a short pulse, a long pulse and CAPTURE_LEN valid samples base+i.
    task automatic runCapture(input logic [31:0] base);
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < CAPTURE_LEN; i++) step(1, base + 32'(i), 0, 0, 0, 0, 0);
    endtask

    initial begin
        // Reset
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        checkOne("reset state", 32'(state_out), 32'd0);
        checkOne("reset timeout_count", 32'(timeout_count), 32'd0);
        checkOne("reset wr_en", 32'(wr_en), 32'd0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Normal capture
        clearLog();
        step(0, 0, 0, 0, 1, 0, 0);
        checkOne("normal arm state", 32'(state_out), 32'd1);
        step(0, 0, 1, 0, 0, 0, 0);
        checkOne("normal short state", 32'(state_out), 32'd2);
        checkOne("normal long_search_en", 32'(long_search_en), 32'd1);
        for (int i = 0; i < 3; i++) step(1, $urandom, 0, 0, 0, 0, 0);
        checkOne("normal still searching", 32'(state_out), 32'd2);
        step(0, 0, 0, 1, 0, 0, 0);
        checkOne("normal capture state", 32'(state_out), 32'd3);
        for (int i = 0; i < 4; i++) begin
            step(1, 32'hA0 + 32'(i), 0, 0, 0, 0, 0);
            checkOne("normal wr_en", 32'(wr_en), 32'd1);
            checkOne("normal wr_addr", 32'(wr_addr), 32'(i));
            checkOne("normal wr_data", wr_data, 32'hA0 + 32'(i));
        end
        checkOne("normal done state", 32'(state_out), 32'd4);
        checkOne("normal capture_done", 32'(capture_done), 32'd1);
        step(0, 0, 0, 0, 0, 0, 0);
        checkOne("normal holdoff 1", 32'(state_out), 32'd5);
        checkOne("normal done cleared", 32'(capture_done), 32'd0);
        step(0, 0, 0, 0, 0, 0, 0);
        checkOne("normal holdoff 2", 32'(state_out), 32'd5);
        step(0, 0, 0, 0, 0, 0, 0);
        checkOne("normal back to idle", 32'(state_out), 32'd0);
        checkOne("normal write count", 32'(log_addr.size()), 32'd4);
        checkOne("normal done pulses", 32'(done_pulses), 32'd1);

        // Timeout
        clearLog();
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(1, $urandom, 0, 0, 0, 0, 0);
        checkOne("timeout 7 valids state", 32'(state_out), 32'd2);
        step(1, $urandom, 0, 0, 0, 0, 0);
        checkOne("timeout state", 32'(state_out), 32'd1);
        checkOne("timeout count", 32'(timeout_count), 32'd1);
        checkOne("timeout no writes", 32'(log_addr.size()), 32'd0);

        // Long detect on the same cycle as the 8th valid
        step(0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(1, $urandom, 0, 0, 0, 0, 0);
        step(1, $urandom, 0, 1, 0, 0, 0);
        checkOne("simultaneous state", 32'(state_out), 32'd3);
        checkOne("simultaneous timeout count", 32'(timeout_count), 32'd1);

        // Abort after two writes
        clearLog();
        step(1, 32'hB0, 0, 0, 0, 0, 0);
        step(1, 32'hB1, 0, 0, 0, 0, 0);
        checkOne("abort second write addr", 32'(wr_addr), 32'd1);
        step(1, 32'hB2, 0, 0, 0, 1, 0);
        checkOne("abort state", 32'(state_out), 32'd0);
        checkOne("abort wr_en", 32'(wr_en), 32'd0);
        for (int i = 0; i < 4; i++) step(1, $urandom, 0, 0, 0, 0, 0);
        checkOne("abort write count", 32'(log_addr.size()), 32'd2);
        checkOne("abort no capture_done", 32'(done_pulses), 32'd0);
        checkOne("abort timeout count", 32'(timeout_count), 32'd1);

        // Auto-rearm
        auto_rearm_in = 1'b1;
        step(0, 0, 0, 0, 1, 0, 0);
        runCapture(32'hC0);
        checkOne("rearm done", 32'(state_out), 32'd4);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        checkOne("rearm holdoff", 32'(state_out), 32'd5);
        step(0, 0, 0, 0, 0, 0, 0);
        checkOne("rearm search_short", 32'(state_out), 32'd1);
        clearLog();
        runCapture(32'hD0);
        checkOne("rearm second write count", 32'(log_addr.size()), 32'd4);
        for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
            checkOne("rearm second addr", 32'(log_addr[i]), 32'(i));
            checkOne("rearm second data", log_data[i], 32'hD0 + 32'(i));
        end
        auto_rearm_in = 1'b0;
        step(0, 0, 0, 0, 0, 1, 0);

        // Reset during CAPTURE, asserted together with abort and a valid sample
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        step(1, 32'hE0, 0, 0, 0, 0, 0);
        step(1, 32'hE1, 0, 0, 0, 0, 0);
        checkOne("pre-reset timeout count", 32'(timeout_count), 32'd1);
        step(1, 32'hE2, 0, 0, 0, 1, 1);
        checkOne("capreset state", 32'(state_out), 32'd0);
        checkOne("capreset wr_en", 32'(wr_en), 32'd0);
        checkOne("capreset wr_addr", 32'(wr_addr), 32'd0);
        checkOne("capreset wr_data", wr_data, 32'd0);
        checkOne("capreset busy", 32'(busy), 32'd0);
        checkOne("capreset capture_done", 32'(capture_done), 32'd0);
        checkOne("capreset long_search_en", 32'(long_search_en), 32'd0);
        checkOne("capreset timeout_count", 32'(timeout_count), 32'd0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Randomized phase, checked cycle by cycle against the model
        for (int i = 0; i < 4000; i++) begin
            if (i % 64 == 0) auto_rearm_in = 1'($urandom_range(0, 1));
            applyStimulus($urandom_range(0, 9) < 7, $urandom,
                          $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
                          $urandom_range(0, 9) == 0, $urandom_range(0, 63) == 0,
                          $urandom_range(0, 255) == 0);
        end
        step(0, 0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/csi_capture_ctrl.md
CSI_CAPTURE_CTRL -- requirements
Module: csi_capture_ctrl

Interface
Parameters:
REQ-001 The block SHALL have parameter LONG_TIMEOUT, default 320, meaning the number of valid samples allowed after a short-preamble detect for the long preamble to appear.
REQ-002 The block SHALL have parameter CAPTURE_LEN, default 64, meaning the number of samples written per capture (range 1..2^ADDR_WIDTH).
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 6, meaning the capture buffer address width.
REQ-004 The block SHALL have parameter HOLDOFF, default 16, meaning the clock cycles spent in HOLDOFF before returning to IDLE (0 allowed).
Ports (name, direction, width, meaning):
REQ-005 The block SHALL have port clk_in, input, 1, the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst_in, input, 1, a synchronous active-high reset.
REQ-007 The block SHALL have port sample_in, input, 32, I[31:16]/Q[15:0] sample, aligned with the detectors' inputs.
REQ-008 The block SHALL have port sample_in_valid, input, 1, the sample qualifier.
REQ-009 The block SHALL have port short_preamble_detected, input, 1, a one-cycle pulse from the short-preamble detector.
REQ-010 The block SHALL have port long_preamble_detected, input, 1, a one-cycle pulse from the long-preamble detector.
REQ-011 The block SHALL have port arm_in, input, 1, a pulse that starts a search from IDLE.
REQ-012 The block SHALL have port auto_rearm_in, input, 1, a level; when high, the block goes from HOLDOFF to SEARCH_SHORT instead of IDLE.
REQ-013 The block SHALL have port abort_in, input, 1, a pulse that forces IDLE.
REQ-014 The block SHALL have port long_search_en, output, 1, high in SEARCH_LONG only; it enables the long-preamble detector.
REQ-015 The block SHALL have port wr_en, output, 1, the capture buffer write strobe.
REQ-016 The block SHALL have port wr_addr, output, ADDR_WIDTH, the capture buffer write address.
REQ-017 The block SHALL have port wr_data, output, 32, the capture buffer write data.
REQ-018 The block SHALL have port capture_done, output, 1, a one-cycle pulse after the last write.
REQ-019 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-020 The block SHALL have port state_out, output, 3, the current state: IDLE=0, SEARCH_SHORT=1, SEARCH_LONG=2, CAPTURE=3, DONE=4, HOLDOFF=5.
REQ-021 The block SHALL have port timeout_count, output, 16, a saturating count of long-preamble timeouts.

Function
REQ-022 In IDLE, arm_in SHALL move the state to SEARCH_SHORT on the next cycle; arm_in SHALL be ignored in all other states.
REQ-023 In SEARCH_SHORT, short_preamble_detected SHALL move the state to SEARCH_LONG and clear the timeout timer.
REQ-024 In SEARCH_LONG, the timer SHALL increment once per sample_in_valid.
REQ-025 In SEARCH_LONG, long_preamble_detected SHALL move the state to CAPTURE and reset wr_addr to 0.
REQ-026 If the timer reaches LONG_TIMEOUT-1 on a valid sample with no long detect, the state SHALL return to SEARCH_SHORT and timeout_count SHALL increment, saturating at 0xFFFF.
REQ-027 A long detect on the same cycle as the timeout SHALL win: the state goes to CAPTURE and there is no timeout increment.
REQ-028 A short_preamble_detected pulse during SEARCH_LONG SHALL restart the timer at 0 without a state change.
REQ-029 In CAPTURE, each sample_in_valid SHALL produce, one cycle later, wr_en=1 with wr_data equal to that sample_in and the current wr_addr; wr_addr SHALL increment after each write.
REQ-030 After the CAPTURE_LEN-th write is accepted, the state SHALL go to DONE; the last write's wr_en and the DONE state SHALL appear on the same cycle.
REQ-031 DONE SHALL last exactly one cycle, with capture_done=1 during it, and then move to HOLDOFF.
REQ-032 HOLDOFF SHALL count HOLDOFF clocks; with HOLDOFF=0 it SHALL last one cycle.
REQ-033 On exit from HOLDOFF, the state SHALL go to SEARCH_SHORT if auto_rearm_in=1, else to IDLE.
REQ-034 Detector pulses outside their search state SHALL be ignored.
REQ-035 abort_in SHALL force IDLE on the next cycle from any state and SHALL take priority over all other transitions.
REQ-036 After an abort, wr_en SHALL be 0 from the next cycle, no capture_done SHALL be produced, and timeout_count SHALL be unchanged.
REQ-037 wr_en SHALL be 0 whenever sample_in_valid was 0 on the previous cycle.
REQ-038 wr_addr SHALL never exceed CAPTURE_LEN-1.

Reset
REQ-039 While rst_in=1 at a clock edge, the state SHALL be IDLE.
REQ-040 Under reset, all outputs (long_search_en, wr_en, wr_addr, wr_data, capture_done, busy, state_out, timeout_count) and both timers SHALL be 0.
REQ-041 Reset SHALL take precedence over abort_in and every other input, including during CAPTURE.

Verification
(LONG_TIMEOUT=8, CAPTURE_LEN=4, HOLDOFF=2)
REQ-042 The bench SHALL check a normal capture: arm, short pulse, long pulse after 3 valids, then 4 valids with samples 0xA0..0xA3 -> writes addr 0..3 with data 0xA0..0xA3, then capture_done for 1 cycle, then HOLDOFF for 2 cycles, then IDLE (auto_rearm=0).
REQ-043 The bench SHALL check timeout: arm, short pulse, 8 valids with no long pulse -> state SEARCH_SHORT and timeout_count=1, with no writes.
REQ-044 The bench SHALL check a simultaneous long detect and 8th valid -> state CAPTURE and timeout_count unchanged.
REQ-045 The bench SHALL check abort mid-capture after 2 writes -> IDLE next cycle, no further wr_en, and capture_done never asserted.
REQ-046 The bench SHALL check auto-rearm: auto_rearm_in=1 through a capture -> state goes HOLDOFF to SEARCH_SHORT, and a second capture writes addr 0..3 again.
REQ-047 The bench SHALL check reset during CAPTURE -> all outputs 0 on the next cycle, state IDLE, and timeout_count cleared.
